// File: rtl/column_sweep_controller_pkg.sv
// Shared definitions for the column sweep controller: FSM states, the node fixed-point
// format (1 sign, 4 integer, 27 fraction bits) and heat colour saturation limits.
package column_sweep_controller_pkg;

  typedef enum logic [2:0] {
    S_WAIT_FLAGS = 3'd0,
    S_DRAIN      = 3'd1,
    S_RELEASE    = 3'd2,
    S_HOLD       = 3'd3,
    S_GUARD      = 3'd4
  } state_t;

  localparam int FP_W         = 32;
  localparam int FP_FRAC_BITS = 27;
  localparam int FP_SIGN_POS  = FP_W - 1;
  localparam int FP_OVF_POS   = FP_W - 2;
  localparam int FP_HEAT_MSB  = FP_W - 3;

  localparam logic signed [FP_W-1:0] FP_8_0 = 32'sh4000_0000;

  localparam int         HEAT_W   = 8;
  localparam logic [7:0] HEAT_MIN = 8'h00;
  localparam logic [7:0] HEAT_MAX = 8'hFF;

endpackage

// File: rtl/column_sweep_controller_fix_to_heat.sv
// Maps a signed fixed-point node value onto an 8-bit heat intensity:
// negatives clamp to black, values of 8.0 and above clamp to full scale.
module fix_to_heat
  import column_sweep_controller_pkg::*;
#(
  parameter int DATA_W = FP_W
) (
  input  logic signed [DATA_W-1:0] i_v,
  output logic        [HEAT_W-1:0] o_heat
);

  // 8.0 is the lowest value whose integer field overflows the visible range
  localparam logic signed [DATA_W-1:0] L_8_0 = {2'b01, {(DATA_W-2){1'b0}}};

  always_comb begin
    o_heat = HEAT_MIN;
    if (i_v < 0) begin
      o_heat = HEAT_MIN;
    end else if (i_v >= L_8_0) begin
      o_heat = HEAT_MAX;
    end else begin
      o_heat = i_v[DATA_W-3 -: HEAT_W];
    end
  end

endmodule

// File: rtl/column_sweep_controller.sv
// Collects one row from the column array once every column flags done, streams it to the
// VGA pixel writer, then pulses start so all columns advance one row together.
module column_sweep_controller
  import column_sweep_controller_pkg::*;
#(
  parameter int NUM_COLS = 32,
  parameter int ROW_BITS = 7,
  parameter int COL_BITS = 7,
  parameter int DATA_W   = FP_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run,
  input  logic [ROW_BITS:0]          height,
  input  logic [NUM_COLS-1:0]        col_flag,
  input  logic [NUM_COLS*DATA_W-1:0] col_node,
  output logic                       start,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [COL_BITS:0]          pix_x,
  output logic [ROW_BITS:0]          pix_y,
  output logic [7:0]                 pix_color,
  output logic [15:0]                sweep_count,
  output logic                       busy
);

  localparam int COL_W = COL_BITS + 1;
  localparam int ROW_W = ROW_BITS + 1;
  localparam int PTR_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_COLS - 1);

  state_t                    r_state;
  logic                      r_start;
  logic                      r_pix_valid;
  logic [COL_W-1:0]          r_pix_x;
  logic [ROW_W-1:0]          r_pix_y;
  logic [7:0]                r_pix_color;
  logic [15:0]               r_sweep;
  logic                      r_busy;
  logic [ROW_W-1:0]          r_row;
  logic [PTR_W-1:0]          r_ptr;
  logic [DATA_W-1:0]         r_cap [NUM_COLS];

  logic                      w_all_flags;
  logic [PTR_W-1:0]          w_next_ptr;
  logic signed [DATA_W-1:0]  w_heat_src;
  logic [7:0]                w_heat;

  assign w_all_flags = &col_flag;
  assign w_next_ptr  = (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;

  // Colour is registered one pixel ahead: the first pixel comes straight off the
  // column bus at capture time, later ones from the capture array.
  assign w_heat_src = (r_state == S_WAIT_FLAGS) ? signed'(col_node[DATA_W-1:0])
                                                : signed'(r_cap[w_next_ptr]);

  fix_to_heat #(.DATA_W(DATA_W)) u_heat (
    .i_v    (w_heat_src),
    .o_heat (w_heat)
  );

  always_ff @(posedge clk) begin
    if (r_state == S_WAIT_FLAGS && w_all_flags) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        r_cap[i] <= col_node[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_WAIT_FLAGS;
      r_start     <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_pix_color <= '0;
      r_sweep     <= '0;
      r_busy      <= 1'b0;
      r_row       <= '0;
      r_ptr       <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_WAIT_FLAGS: begin
          if (w_all_flags) begin
            r_state     <= S_DRAIN;
            r_pix_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_ptr       <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= r_row;
            r_pix_color <= w_heat;
          end
        end
        S_DRAIN: begin
          if (r_pix_valid && pix_ready) begin
            if (r_ptr == LAST_PTR) begin
              r_ptr       <= '0;
              r_pix_valid <= 1'b0;
              if (run) begin
                r_state <= S_RELEASE;
                r_start <= 1'b1;
              end else begin
                r_state <= S_HOLD;
                r_busy  <= 1'b0;
              end
            end else begin
              r_ptr       <= w_next_ptr;
              r_pix_x     <= COL_W'(w_next_ptr);
              r_pix_color <= w_heat;
            end
          end
        end
        S_HOLD: begin
          if (run) begin
            r_state <= S_RELEASE;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        S_RELEASE: begin
          r_state <= S_GUARD;
        end
        S_GUARD: begin
          // A height lowered below the current row still wraps here
          if (r_row >= height) begin
            r_row   <= '0;
            r_sweep <= r_sweep + 16'd1;
          end else begin
            r_row <= r_row + 1'b1;
          end
          r_state <= S_WAIT_FLAGS;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_WAIT_FLAGS;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign start       = r_start;
  assign pix_valid   = r_pix_valid;
  assign pix_x       = r_pix_x;
  assign pix_y       = r_pix_y;
  assign pix_color   = r_pix_color;
  assign sweep_count = r_sweep;
  assign busy        = r_busy;

endmodule

// File: tb/tb_column_sweep_controller.sv
// Scoreboard bench for column_sweep_controller: a column-array model issues rows and queues
// the expected pixels; an independent monitor checks every pixel handshake and start pulse.
module tb_column_sweep_controller;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int RB = 7;
  localparam int CB = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              run = 1'b1;
  logic [RB:0]       height = 8'd3;
  logic [NC-1:0]     col_flag = '0;
  logic [NC*DW-1:0]  col_node = '0;
  logic              pix_ready = 1'b1;
  logic              start;
  logic              pix_valid;
  logic [CB:0]       pix_x;
  logic [RB:0]       pix_y;
  logic [7:0]        pix_color;
  logic [15:0]       sweep_count;
  logic              busy;

  column_sweep_controller #(.NUM_COLS(NC), .ROW_BITS(RB), .COL_BITS(CB), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .run(run), .height(height), .col_flag(col_flag),
    .col_node(col_node), .start(start), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .sweep_count(sweep_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int color; bit last; } pix_t;
  pix_t q[$];

  int n_vec = 0;
  int n_fail = 0;
  int ready_mode = 0;
  int row_model = 0;
  int sweep_model = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference colour from the real-valued node, not from its bit fields
  function automatic int ref_color(input logic signed [DW-1:0] v);
    real r;
    r = $itor(v) / 134217728.0;
    if (r < 0.0) return 0;
    if (r >= 8.0) return 255;
    return int'($floor(r * 32.0));
  endfunction

  function automatic logic signed [DW-1:0] gen_node();
    logic signed [DW-1:0] v;
    int tmp;
    case ($urandom_range(0, 4))
      0: begin tmp = int'($urandom_range(1, 32'h7FFF_FFFF)); v = -tmp; end
      1: v = 32'h4000_0000 + $urandom_range(0, 32'h3FFF_FFFF);
      2: v = ($urandom_range(0, 1) != 0) ? 32'sh4000_0000 : 32'sh3FFF_FFFF;
      default: v = $urandom_range(0, 32'h3FFF_FFFF);
    endcase
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ~pix_ready;
        default: pix_ready = 1'(($urandom_range(0, 1)));
      endcase
    end
  end

  // Monitor: pixel handshakes, stability under backpressure, start pulse timing/width
  logic        m_pv = 0, m_pr = 0, m_ps = 0;
  bit          m_pend = 0;
  logic [CB:0] m_px = 0;
  logic [RB:0] m_py = 0;
  logic [7:0]  m_pc = 0;
  pix_t        m_e;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_pv = 0; m_ps = 0; m_pend = 0;
      end else begin
        if (m_pend) begin
          chk("start_after_last_pixel", start, 1);
          m_pend = 0;
        end else if (m_ps) begin
          chk("start_width", start, 0);
        end
        if (m_pv && !m_pr && pix_valid) begin
          chk("stall_x", pix_x, m_px);
          chk("stall_y", pix_y, m_py);
          chk("stall_color", pix_color, m_pc);
        end
        if (pix_valid && pix_ready) begin
          if (q.size() == 0) begin
            n_vec++; n_fail++;
            $display("FAIL extra_pixel: got x=%0d y=%0d, expected none", pix_x, pix_y);
          end else begin
            m_e = q.pop_front();
            chk("pix_x", pix_x, m_e.x);
            chk("pix_y", pix_y, m_e.y);
            chk("pix_color", pix_color, m_e.color);
            if (m_e.last) m_pend = run;
          end
        end
        m_pv = pix_valid; m_pr = pix_ready; m_ps = start;
        m_px = pix_x; m_py = pix_y; m_pc = pix_color;
      end
    end
  end

  task automatic do_row(input bit one_by_one, input bit hold, input int rmode, input bit fixed);
    logic signed [DW-1:0] fixed_vals [NC];
    logic signed [DW-1:0] v;
    int perm [NC];
    int t, j, tmp;
    fixed_vals[0] = 32'shF800_0000;
    fixed_vals[1] = 32'sh0000_0000;
    fixed_vals[2] = 32'sh2000_0000;
    fixed_vals[3] = 32'sh4800_0000;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_valid", pix_valid, 0);
    chk("sweep_count", sweep_count, sweep_model);
    ready_mode = rmode;
    for (int c = 0; c < NC; c++) begin
      v = fixed ? fixed_vals[c] : gen_node();
      col_node[c*DW +: DW] = v;
      q.push_back('{c, row_model, ref_color(v), c == NC-1});
    end
    if (one_by_one) begin
      for (int c = 0; c < NC; c++) perm[c] = c;
      for (int c = NC-1; c > 0; c--) begin
        j = $urandom_range(0, c); tmp = perm[c]; perm[c] = perm[j]; perm[j] = tmp;
      end
      for (int k = 0; k < NC; k++) begin
        col_flag[perm[k]] = 1'b1;
        @(posedge clk); #1;
        chk("flag_gate_valid", pix_valid, (k == NC-1) ? 1 : 0);
      end
    end else begin
      col_flag = '1;
      @(posedge clk); #1;
      chk("first_valid", pix_valid, 1);
    end
    chk("drain_busy", busy, 1);
    // Columns' buses and flags are no longer trusted once captured
    for (int c = 0; c < NC; c++) col_node[c*DW +: DW] = $urandom;
    if ($urandom_range(0, 1) != 0) col_flag = '0;
    if (hold) run = 1'b0;
    t = 0;
    while (q.size() != 0 && t < 500) begin @(posedge clk); #1; t++; end
    chk("drain_done", q.size(), 0);
    if (hold) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("hold_no_start", start, 0);
        chk("hold_busy", busy, 0);
      end
      run = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_start", start, 1);
    end else begin
      t = 0;
      while (!start && t < 20) begin @(posedge clk); #1; t++; end
      chk("start_seen", start, 1);
    end
    @(posedge clk); #1;
    chk("guard_start_low", start, 0);
    chk("guard_busy", busy, 1);
    col_flag = '0;
    if (row_model >= int'(height)) begin row_model = 0; sweep_model++; end
    else row_model++;
  endtask

  task automatic reset_mid_drain();
    logic signed [DW-1:0] v;
    int t;
    @(posedge clk); #1;
    chk("pre_reset_sweep", sweep_count, sweep_model);
    ready_mode = 0;
    for (int c = 0; c < NC; c++) begin
      v = gen_node();
      col_node[c*DW +: DW] = v;
      q.push_back('{c, row_model, ref_color(v), c == NC-1});
    end
    col_flag = '1;
    t = 0;
    while (q.size() > 2 && t < 50) begin @(posedge clk); #1; t++; end
    chk("reached_pixel2", pix_x, 2);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_color", pix_color, 0);
    chk("rst_sweep", sweep_count, 0);
    q.delete();
    col_flag = '0;
    row_model = 0;
    sweep_model = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_reset_wait", pix_valid, 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", pix_valid, 0);
    chk("reset_start", start, 0);
    chk("reset_busy", busy, 0);
    chk("reset_x", pix_x, 0);
    chk("reset_y", pix_y, 0);
    chk("reset_color", pix_color, 0);
    chk("reset_sweep", sweep_count, 0);
    reset = 1'b1;
    do_row(1, 0, 0, 1);
    do_row(0, 0, 1, 0);
    for (int r = 2; r < 8; r++) begin
      do_row(1'($urandom_range(0, 1)), r == 5, 2, 0);
    end
    reset_mid_drain();
    do_row(0, 0, 2, 0);
    do_row(1, 0, 1, 0);
    @(posedge clk); #1;
    chk("final_queue_empty", q.size(), 0);
    chk("final_sweep", sweep_count, sweep_model);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
